// File: rtl/sbox_arb_pkg.sv
// rtl/sbox_arb_pkg.sv - shared types and round-robin pick function for the S-box access arbiter
package sbox_arb_pkg;

  localparam int SBOX_AW = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  // First set request bit scanning ptr, ptr+1, ... modulo num_req; returns ptr when none is set.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0] ptr,
                                         input int num_req);
    logic [2:0] pick;
    int j;
    pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < num_req) begin
        j = (int'(ptr) + k) % num_req;
        if (req[j[2:0]]) pick = j[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sbox_access_arbiter_rr_arbiter.sv
// rtl/sbox_access_arbiter_rr_arbiter.sv - combinational round-robin picker over NUM_REQ requesters
module rr_arbiter
  import sbox_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               valid,
  output logic [IDW-1:0]     idx
);

  logic [MAX_REQ-1:0] req_ext;
  logic [2:0]         ptr_ext;

  assign req_ext = MAX_REQ'(req);
  assign ptr_ext = 3'(ptr);
  assign valid   = |req;
  assign idx     = IDW'(rr_pick(req_ext, ptr_ext, NUM_REQ));

endmodule

// File: rtl/sbox_access_arbiter.sv
// rtl/sbox_access_arbiter.sv - serialises S-box lookups from NUM_REQ requesters onto one memory port
module sbox_access_arbiter
  import sbox_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [SBOX_AW*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [SBOX_AW-1:0]         rsp_data,
  output logic                       rsp_err,
  output logic [SBOX_AW-1:0]         sbox_rqst_addr,
  output logic                       flag_address_sent,
  input  logic                       addr_ack,
  input  logic                       flag_data_sent,
  input  logic [SBOX_AW-1:0]         sbox_read_data,
  output logic                       data_ack,
  output logic                       busy,
  output logic [IDW-1:0]             grant_id,
  output logic                       timeout_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t             state;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ptr_next;
  logic [IDW-1:0]     arb_idx;
  logic               arb_valid;
  logic [CW-1:0]      wait_cnt;
  logic               wd_hit;
  logic               abort;
  logic [NUM_REQ-1:0] grant_onehot;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  generate
    if (TIMEOUT == 0) begin : g_no_wd
      assign wd_hit = 1'b0;
    end else begin : g_wd
      assign wd_hit = (wait_cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

  // Handshake progress in the final watchdog cycle wins over the timeout.
  assign abort = wd_hit && (((state == ADDR) && !addr_ack) ||
                            ((state == DATA) && !flag_data_sent));

  assign grant_onehot = NUM_REQ'(1) << grant_id;
  assign ptr_next     = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      ptr               <= '0;
      wait_cnt          <= '0;
      grant_id          <= '0;
      sbox_rqst_addr    <= '0;
      flag_address_sent <= 1'b0;
      rsp_valid         <= '0;
      rsp_data          <= '0;
      rsp_err           <= 1'b0;
      data_ack          <= 1'b0;
      busy              <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      data_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_id          <= arb_idx;
            sbox_rqst_addr    <= req_addr[arb_idx*SBOX_AW +: SBOX_AW];
            flag_address_sent <= 1'b1;
            busy              <= 1'b1;
            wait_cnt          <= '0;
            state             <= ADDR;
          end
        end
        ADDR: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (addr_ack) begin
            flag_address_sent <= 1'b0;
            wait_cnt          <= '0;
            if (flag_data_sent) begin
              rsp_data  <= sbox_read_data;
              rsp_valid <= grant_onehot;
              data_ack  <= 1'b1;
              state     <= RESP;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (flag_data_sent) begin
            rsp_data  <= sbox_read_data;
            rsp_valid <= grant_onehot;
            data_ack  <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          ptr   <= ptr_next;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (abort) begin
        flag_address_sent <= 1'b0;
        rsp_data          <= '0;
        rsp_valid         <= grant_onehot;
        rsp_err           <= 1'b1;
        timeout_err       <= 1'b1;
        busy              <= 1'b0;
        state             <= IDLE;
      end
    end
  end

endmodule
